// File: rtl/fp_addsub_pkg.sv
// fp_addsub_pkg: shared FSM states, rounding modes, flag indices and format helpers for fp_addsub_param
package fp_addsub_pkg;
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_UNPACK  = 4'd1;
  localparam logic [3:0] S_SPECIAL = 4'd2;
  localparam logic [3:0] S_ALIGN   = 4'd3;
  localparam logic [3:0] S_ADD     = 4'd4;
  localparam logic [3:0] S_NORM    = 4'd5;
  localparam logic [3:0] S_ROUND   = 4'd6;
  localparam logic [3:0] S_PACK    = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;
  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RUP = 2'd2;
  localparam logic [1:0] RM_RDN = 2'd3;
  localparam int FLAG_INV = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_INX = 0;
  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction
  function automatic logic [127:0] qnan(input int exp_w, input int man_w);
    return (((128'd1 << exp_w) - 128'd1) << man_w) | (128'd1 << (man_w - 1));
  endfunction
endpackage

// File: rtl/fp_round.sv
// fp_round: combinational round-to-nearest-even / directed rounding incrementer
module fp_round
  import fp_addsub_pkg::*;
#(
  parameter int MAN_W = 23
) (
  input  logic [MAN_W:0] sig,
  input  logic           g,
  input  logic           r,
  input  logic           s,
  input  logic           sign,
  input  logic [1:0]     mode,
  output logic [MAN_W:0] rounded,
  output logic           carry,
  output logic           inexact
);
  logic inc;
  assign inexact = g | r | s;
  always_comb
    inc = mode == RM_RTZ ? 1'b0 :
          mode == RM_RUP ? !sign && inexact :
          mode == RM_RDN ? sign && inexact :
          g && (r || s || sig[0]);
  assign {carry, rounded} = {1'b0, sig} + {{(MAN_W + 1){1'b0}}, inc};
endmodule

// File: rtl/fp_addsub_param.sv
// fp_addsub_param: multi-cycle IEEE-754 add/sub with valid/ready, RNE rounding and flags; FP_ADDSUB_RMODE_EN adds an rmode port
module fp_addsub_param
  import fp_addsub_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op_sub,
`ifdef FP_ADDSUB_RMODE_EN
  input  logic [1:0]   rmode,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [2:0]   flags
);
  localparam int SW = MAN_W + 4;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] ONE = EW'(1);
  localparam logic signed [EW-1:0] EMAX = EW'(2 * bias(EXP_W) + 1);
  localparam logic signed [EW-1:0] ALIGN_MAX = EW'(MAN_W + 3);
  localparam logic [127:0] QNAN_WIDE = qnan(EXP_W, MAN_W);
  localparam logic [W-1:0] QNAN = QNAN_WIDE[W-1:0];

  logic [3:0] state;
  logic [W-1:0] a_r, b_r;
  logic sub_r, sa, sb, rs, inx, spec;
  logic [1:0] mode;
  logic signed [EW-1:0] ea, eb, re, diff;
  logic [SW-1:0] ma, mb, mag;
  logic [SW:0] rm, sum;
  logic ge, cancel;
  logic [EXP_W-1:0] exp_a, exp_b, pexp;
  logic [MAN_W-1:0] frac_a, frac_b;
  logic sbe, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, spec_hit, ovf, sat;
  logic [W-1:0] sres, pres;
  logic [2:0] sflg, pflg;
  logic [MAN_W:0] rnd;
  logic rc, rinx;

  assign in_ready = state == S_IDLE;
  assign out_valid = state == S_DONE;

  assign exp_a = a_r[W-2:MAN_W];
  assign exp_b = b_r[W-2:MAN_W];
  assign frac_a = a_r[MAN_W-1:0];
  assign frac_b = b_r[MAN_W-1:0];
  assign sbe = b_r[W-1] ^ sub_r;
  assign nan_a = &exp_a && |frac_a;
  assign nan_b = &exp_b && |frac_b;
  assign inf_a = &exp_a && !(|frac_a);
  assign inf_b = &exp_b && !(|frac_b);
  assign zero_a = !(|a_r[W-2:0]);
  assign zero_b = !(|b_r[W-2:0]);

  // Special operands bypass the arithmetic pipeline entirely
  always_comb begin
    sflg = '0;
    sflg[FLAG_INV] = inf_a && inf_b && (a_r[W-1] != sbe);
    spec_hit = nan_a || nan_b || inf_a || inf_b || zero_a || zero_b;
    sres = (nan_a || nan_b || sflg[FLAG_INV]) ? QNAN :
           inf_a ? a_r :
           inf_b ? {sbe, b_r[W-2:0]} :
           (zero_a && zero_b) ? {a_r[W-1] & sbe, {(W-1){1'b0}}} :
           zero_a ? {sbe, b_r[W-2:0]} : a_r;
  end

  assign diff = ea - eb;
  assign ge = ma >= mb;
  assign sum = {1'b0, ma} + {1'b0, mb};
  assign mag = ge ? ma - mb : mb - ma;
  assign cancel = (sa != sb) && (ma == mb);

  fp_round #(.MAN_W(MAN_W)) u_round (
    .sig(rm[SW-1:3]),
    .g(rm[2]),
    .r(rm[1]),
    .s(rm[0]),
    .sign(rs),
    .mode(mode),
    .rounded(rnd),
    .carry(rc),
    .inexact(rinx)
  );

  // Overflow saturates to max finite when the mode rounds toward zero for this sign
  always_comb begin
    pflg = '0;
    ovf = re >= EMAX;
    sat = mode == RM_RTZ || (mode == RM_RUP && rs) || (mode == RM_RDN && !rs);
    pflg[FLAG_OVF] = ovf;
    pflg[FLAG_INX] = ovf | inx;
    pexp = rm[SW-1] ? re[EXP_W-1:0] : '0;
    pres = !ovf ? {rs, pexp, rm[SW-2:3]} :
           sat ? {rs, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}} :
           {rs, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      result <= '0;
      flags <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          a_r <= a;
          b_r <= b;
          sub_r <= op_sub;
`ifdef FP_ADDSUB_RMODE_EN
          mode <= rmode;
`else
          mode <= RM_RNE;
`endif
          state <= S_UNPACK;
        end
        S_UNPACK: begin
          sa <= a_r[W-1];
          sb <= sbe;
          ea <= (|exp_a) ? {2'b00, exp_a} : ONE;
          eb <= (|exp_b) ? {2'b00, exp_b} : ONE;
          ma <= {|exp_a, frac_a, 3'b000};
          mb <= {|exp_b, frac_b, 3'b000};
          state <= S_SPECIAL;
        end
        S_SPECIAL: begin
          spec <= spec_hit;
          if (spec_hit) begin
            result <= sres;
            flags <= sflg;
            state <= S_PACK;
          end else begin
            if (eb > ea) begin
              {sa, sb} <= {sb, sa};
              {ea, eb} <= {eb, ea};
              {ma, mb} <= {mb, ma};
            end
            state <= S_ALIGN;
          end
        end
        S_ALIGN:
          if (diff > ALIGN_MAX) begin
            mb <= {{(SW-1){1'b0}}, |mb};
            eb <= ea;
            state <= S_ADD;
          end else if (diff == '0) state <= S_ADD;
          else begin
            mb <= {1'b0, mb[SW-1:2], mb[1] | mb[0]};
            eb <= eb + ONE;
          end
        S_ADD: begin
          rm <= sa == sb ? sum : {1'b0, mag};
          rs <= cancel ? mode == RM_RDN : (sa == sb || ge) ? sa : sb;
          re <= cancel ? ONE : ea;
          state <= S_NORM;
        end
        S_NORM:
          if (rm[SW] || re < ONE) begin
            rm <= {1'b0, rm[SW:2], rm[1] | rm[0]};
            re <= re + ONE;
          end else if (!rm[SW-1] && re > ONE) begin
            rm <= {rm[SW-1:0], 1'b0};
            re <= re - ONE;
          end else state <= S_ROUND;
        S_ROUND: begin
          rm <= rc ? {2'b01, {MAN_W{1'b0}}, 3'b000} : {1'b0, rnd, 3'b000};
          re <= rc ? re + ONE : re;
          inx <= rinx;
          state <= S_PACK;
        end
        S_PACK: begin
          if (!spec) begin
            result <= pres;
            flags <= pflg;
          end
          state <= S_DONE;
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_param.sv
// tb_fp_addsub_param: directed self-checking bench for fp_addsub_param at single-precision defaults
module tb_fp_addsub_param;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] r;
    logic [2:0]  f;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic op_sub = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic in_ready, out_valid;
  logic [31:0] result;
  logic [2:0] flags;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_addsub_param dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .op_sub(op_sub),
`ifdef FP_ADDSUB_RMODE_EN
    .rmode(2'b00),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .flags(flags)
  );

  task automatic run_op(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                        output logic [31:0] r, output logic [2:0] f, output logic ok);
    int n = 0;
    a = va;
    b = vb;
    op_sub = vs;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    ok = out_valid;
    r = result;
    f = flags;
  endtask

  task automatic finish_op;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_table(input string name, input vec_t v);
    logic [31:0] r;
    logic [2:0] f;
    logic ok;
    run_op(v.a, v.b, v.s, r, f, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL %s timeout out_valid=%b", name, out_valid); end
    checks++;
    if (r !== v.r) begin failures++; $display("FAIL %s result got=%h exp=%h", name, r, v.r); end
    checks++;
    if (f !== v.f) begin failures++; $display("FAIL %s flags got=%b exp=%b", name, f, v.f); end
    finish_op;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++;
    if (flags !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", flags); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_hold;
    logic [31:0] r;
    logic [2:0] f;
    logic ok;
    run_op(32'h3F800000, 32'h40000000, 1'b0, r, f, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL add timeout out_valid=%b", out_valid); end
    checks++;
    if (r !== 32'h40400000) begin failures++; $display("FAIL add result got=%h exp=40400000", r); end
    checks++;
    if (f !== 3'b000) begin failures++; $display("FAIL add flags got=%b exp=000", f); end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL busy_in_ready got=%b exp=0", in_ready); end
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_out_valid got=%b exp=1", out_valid); end
    checks++;
    if (result !== 32'h40400000) begin failures++; $display("FAIL hold_result got=%h exp=40400000", result); end
    finish_op;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL after_xfer_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL after_xfer_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_sub_cancel;
    run_table("sub_cancel", '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000});
    run_table("sub_half", '{32'h3F800000, 32'h3F000000, 1'b1, 32'h3F000000, 3'b000});
  endtask

  task automatic test_specials;
    vec_t v[5];
    v[0] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100};
    v[1] = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000};
    v[2] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000};
    v[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000};
    v[4] = '{32'h00000000, 32'h40490FDB, 1'b0, 32'h40490FDB, 3'b000};
    for (int i = 0; i < 5; i++) run_table($sformatf("special%0d", i), v[i]);
  endtask

  task automatic test_boundaries;
    run_table("overflow", '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011});
    run_table("denorm_add", '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000});
    run_table("denorm_to_norm", '{32'h007FFFFF, 32'h00000001, 1'b0, 32'h00800000, 3'b000});
  endtask

  task automatic test_rounding;
    vec_t v[3];
    v[0] = '{32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 3'b001};
    v[1] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001};
    v[2] = '{32'h3F800000, 32'h0D800000, 1'b0, 32'h3F800000, 3'b001};
    for (int i = 0; i < 3; i++) run_table($sformatf("round%0d", i), v[i]);
  endtask

  task automatic test_abort_reset;
    logic seen = 1'b0;
    a = 32'h3F800000;
    b = 32'h40000000;
    op_sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_out_valid got=%b exp=0", out_valid); end
    repeat (40) begin @(posedge clk); #1; seen |= out_valid; end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL abort_emitted got=%b exp=0", seen); end
    run_table("after_abort", '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000});
  endtask

  initial begin
    test_reset;
    test_add_hold;
    test_sub_cancel;
    test_specials;
    test_boundaries;
    test_rounding;
    test_abort_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule
